usb_bus_master: RTL
===================

# usb_bus_master

Hardware bus-cycle engine for the 8-bit parallel host interface of the board's USB controller chip. It replaces software bit-banging of the bidirectional data PIO and the separate strobe PIOs. An Avalon-MM slave accepts data and command accesses and converts each into one complete, timed external read or write cycle. Each cycle drives cs_n, rd_n, wr_n, a0 and the bidirectional data bus, and stalls the master with waitrequest until the cycle completes.

## Interface
Parameters:
- DEF_SETUP, 1, reset value of the setup count (cycles, 1..15)
- DEF_STROBE, 2, reset value of the strobe count (cycles, 1..15)
- DEF_HOLD, 1, reset value of the hold count (cycles, 1..15)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  2  0 = data port (a0=0), 1 = command port (a0=1), 2 = timing register, 3 = cycle counter
- chipselect  in  1  slave select
- read_n  in  1  active-low read request
- write_n  in  1  active-low write request
- writedata  in  32  write data; bits [7:0] are used on the bus
- readdata  out  32  registered read data, zero-extended
- waitrequest  out  1  stall to the Avalon master
- usb_data  inout  8  external data bus
- usb_cs_n  out  1  chip select
- usb_rd_n  out  1  read strobe
- usb_wr_n  out  1  write strobe
- usb_a0  out  1  data/command select

## Operation
- Request: chipselect & (~read_n | ~write_n). If both read_n and write_n are low, the write wins.
- State machine states: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE, request to address 0/1 → SETUP.
  - Latch a0 = address[0], the direction, and writedata[7:0].
  - Load the counter with setup.
- IDLE, request to address 2/3 → DONE.
  - A timing write takes effect on this edge.
- SETUP: usb_cs_n = 0, usb_a0 valid, and the bus is driven if the cycle is a write. When the counter expires → STROBE, loading the strobe count.
- STROBE: usb_rd_n = 0 (read) or usb_wr_n = 0 (write). When the counter expires → HOLD, loading the hold count. Read data is captured on this same edge.
- HOLD: strobes high, usb_cs_n still 0, write data still driven. When the counter expires → DONE.
- DONE: waitrequest = 0 for exactly one cycle, readdata valid, then → IDLE. The cycle counter (address 3) increments on entry to DONE from HOLD.
- waitrequest = request & (state != DONE). It is 0 when there is no request.
- Timing register (address 2): [3:0] setup, [7:4] strobe, [11:8] hold, other bits read 0. A field value of 0 is treated as 1.
- Cycle counter (address 3): 16-bit, wraps FFFF → 0000. A write to address 3 clears it.
- usb_data is driven only while a write cycle is in SETUP, STROBE or HOLD. Otherwise it is Z.
- A read of address 0/1 returns {24'b0, captured byte}. A write to address 0/1 leaves readdata unchanged.

## Timing
- Reset values:
  - state IDLE, usb_cs_n = usb_rd_n = usb_wr_n = 1, usb_a0 = 0, usb_data = Z
  - readdata = 0, waitrequest = 0 with no request
  - timing = {DEF_HOLD, DEF_STROBE, DEF_SETUP}, counter = 0
- Bus access latency from request assertion to DONE: 1 + S + T + H cycles. waitrequest is low in the following cycle.
- Register access (address 2/3): one wait cycle, then DONE.
- Reset mid-cycle: strobes, cs_n and the bus driver release immediately (asynchronous). No partial strobe is extended.
- A timing write never alters a cycle already in progress. Counts are latched in IDLE.
- Back-to-back requests: IDLE always separates two external cycles. cs_n is high for at least 2 cycles between cycles (DONE plus IDLE).

## Structure
- Shared package usb_bus_pkg:
  - state encoding constants
  - register address constants (ADDR_DATA, ADDR_CMD, ADDR_TIMING, ADDR_COUNT)
  - timing field bit positions
- One natural sub-module, usb_bus_timer: 4-bit loadable down-counter with a zero-treated-as-one load and an expire output.

## Test plan
- Reset defaults: write 0x5A to address 0 → usb_wr_n low for 2 cycles, usb_data = 0x5A, usb_a0 = 0, waitrequest high for 5 cycles.
- Read address 1 with the bus model returning 0xC3 → usb_rd_n low for 2 cycles, usb_a0 = 1, readdata = 0x000000C3, usb_data never driven by the DUT.
- Timing write of 0x00000F3 (setup=3, strobe=15, hold=0) → the next access shows setup 3, strobe 15 and hold 1, and address 2 reads back 0x000000F3.
- Assert reset_n during STROBE of a write → same cycle: usb_wr_n = 1, usb_cs_n = 1, usb_data = Z; the timing register returns to defaults.
- Three back-to-back writes → the counter at address 3 reads 3 and cs_n stays high for at least 2 cycles between cycles. Clearing the counter then reading it returns 0.
- Preload the counter to 0xFFFF via 65535 cycles (or force), then do one more access → it reads 0x0000.

Source files
------------

// File: rtl/usb_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : usb_bus_pkg
// Purpose  : Shared state, register-address and timing-field definitions
//            for the USB controller host-interface bus master.
// Revision : 1.0  initial release
// ============================================================================
package usb_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_STROBE = 3'd2,
      ST_HOLD   = 3'd3,
      ST_DONE   = 3'd4
   } bus_state_t;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_CMD    = 2'd1;
   localparam logic [1:0] ADDR_TIMING = 2'd2;
   localparam logic [1:0] ADDR_COUNT  = 2'd3;

   localparam int FIELD_W    = 4;
   localparam int SETUP_LSB  = 0;
   localparam int STROBE_LSB = 4;
   localparam int HOLD_LSB   = 8;

   // A programmed phase length of zero still occupies one clock.
   function automatic logic [3:0] eff_count(input logic [3:0] raw);
      return (raw == 4'd0) ? 4'd1 : raw;
   endfunction

endpackage
`default_nettype wire

// File: rtl/usb_bus_timer.sv
`default_nettype none
// ============================================================================
// Module   : usb_bus_timer
// Purpose  : 4-bit loadable down-counter timing one bus phase; expire is
//            high during the last cycle of the loaded phase length.
// Revision : 1.0  initial release
// ============================================================================
module usb_bus_timer
   import usb_bus_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load,
   input  logic [3:0] load_value,
   output logic       expire
);

   logic [3:0] r_count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= 4'd0;
      end else if (load) begin
         r_count <= eff_count(load_value);
      end else if (r_count != 4'd0) begin
         r_count <= r_count - 4'd1;
      end
   end

   assign expire = (r_count == 4'd1);

endmodule
`default_nettype wire

// File: rtl/usb_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : usb_bus_master
// Purpose  : Avalon-MM slave turning each data/command access into one timed
//            external read or write cycle on the USB controller's 8-bit bus.
// Revision : 1.0  initial release
// ============================================================================
module usb_bus_master
   import usb_bus_pkg::*;
#(
   parameter int DEF_SETUP  = 1,
   parameter int DEF_STROBE = 2,
   parameter int DEF_HOLD   = 1
)(
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        read_n,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        waitrequest,
   inout  wire  [7:0]  usb_data,
   output logic        usb_cs_n,
   output logic        usb_rd_n,
   output logic        usb_wr_n,
   output logic        usb_a0
);

   bus_state_t  r_state, w_next;
   logic        w_request, w_write, w_is_bus;
   logic        w_load, w_expire, w_drive;
   logic [3:0]  w_load_val;
   logic [11:0] r_timing;
   logic [3:0]  r_strobe_cnt, r_hold_cnt;
   logic        r_a0, r_write;
   logic [7:0]  r_wdata;
   logic [31:0] r_readdata;
   logic [15:0] r_count, w_count_next;
   logic        w_count_clr, w_count_en;
   logic        w_unused;

   assign w_request = chipselect & (~read_n | ~write_n);
   assign w_write   = ~write_n;
   assign w_is_bus  = (address == ADDR_DATA) || (address == ADDR_CMD);
   assign w_unused  = &{1'b0, writedata[31:12]};

   usb_bus_timer u_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (w_load),
      .load_value (w_load_val),
      .expire     (w_expire)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   // Strobes and chip select decode straight from the state register so an
   // asynchronous reset releases them in the same instant.
   always_comb begin
      w_next     = r_state;
      w_load     = 1'b0;
      w_load_val = r_timing[SETUP_LSB +: FIELD_W];
      usb_cs_n   = 1'b1;
      usb_rd_n   = 1'b1;
      usb_wr_n   = 1'b1;
      w_drive    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_request) begin
               w_load = w_is_bus;
               w_next = w_is_bus ? ST_SETUP : ST_DONE;
            end
         end
         ST_SETUP: begin
            usb_cs_n = 1'b0;
            w_drive  = r_write;
            if (w_expire) begin
               w_next     = ST_STROBE;
               w_load     = 1'b1;
               w_load_val = r_strobe_cnt;
            end
         end
         ST_STROBE: begin
            usb_cs_n = 1'b0;
            w_drive  = r_write;
            usb_rd_n = r_write;
            usb_wr_n = ~r_write;
            if (w_expire) begin
               w_next     = ST_HOLD;
               w_load     = 1'b1;
               w_load_val = r_hold_cnt;
            end
         end
         ST_HOLD: begin
            usb_cs_n = 1'b0;
            w_drive  = r_write;
            if (w_expire) w_next = ST_DONE;
         end
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   assign waitrequest = w_request & (r_state != ST_DONE);
   assign usb_a0      = r_a0;
   assign usb_data    = w_drive ? r_wdata : 8'hzz;
   assign readdata    = r_readdata;

   assign w_count_clr  = (r_state == ST_IDLE) && w_request && w_write && (address == ADDR_COUNT);
   assign w_count_en   = w_count_clr || ((r_state == ST_HOLD) && w_expire);
   assign w_count_next = w_count_clr ? 16'h0000 : r_count + 16'd1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_timing     <= {4'(DEF_HOLD), 4'(DEF_STROBE), 4'(DEF_SETUP)};
         r_strobe_cnt <= 4'd0;
         r_hold_cnt   <= 4'd0;
         r_a0         <= 1'b0;
         r_write      <= 1'b0;
         r_wdata      <= 8'h00;
         r_readdata   <= 32'h0;
         r_count      <= 16'h0000;
      end else begin
         // Phase counts are captured here so a later timing write cannot
         // reshape a cycle that has already started.
         if ((r_state == ST_IDLE) && w_request) begin
            if (w_is_bus) begin
               r_a0         <= address[0];
               r_write      <= w_write;
               r_wdata      <= writedata[7:0];
               r_strobe_cnt <= r_timing[STROBE_LSB +: FIELD_W];
               r_hold_cnt   <= r_timing[HOLD_LSB +: FIELD_W];
            end else if (address == ADDR_TIMING) begin
               if (w_write) r_timing   <= writedata[11:0];
               else         r_readdata <= {20'h0, r_timing};
            end else if (!w_write) begin
               r_readdata <= {16'h0, r_count};
            end
         end
         if ((r_state == ST_STROBE) && w_expire && !r_write)
            r_readdata <= {24'h0, usb_data};
         if (w_count_en)
            r_count <= w_count_next;
      end
   end

endmodule
`default_nettype wire
